fft16_twiddle_seq: RTL
======================

Name: fft16_twiddle_seq

Overview:
- Feeds the W16 rotator (the 0.924/0.383, 0.707 and -j multipliers) between the two radix-4 passes of the 16-point FFT inside the 256-point core.
- Accepts one complex sample at a time over a valid/ready handshake.
- Presents each sample in the two-phase strobe form the rotator consumes: ED high with the sample, ED low on the following EI cycle.
- Decodes the twiddle exponent e = n2*k1 into rotator control flags, so the rotator needs no address logic of its own.

Parameters:
- nb, 12, sample width of the real and imaginary parts (two's complement).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EI  in  1  global clock enable; when low, all state and outputs hold.
- START  in  1  begins a 16-sample frame; sampled only in IDLE.
- IN_VLD  in  1  input sample valid.
- IN_RDY  out  1  sample accepted when IN_VLD & IN_RDY & EI.
- DIR  in  nb  input real part.
- DII  in  nb  input imaginary part.
- DOR  out  nb  real part to the rotator.
- DOI  out  nb  imaginary part to the rotator.
- ED  out  1  data strobe, high for exactly one EI cycle per sample.
- SEL  out  2  rotator path: 0 bypass, 1 c924/383, 2 c707.
- MPYJ  out  1  multiply the result by -j.
- C383  out  1  use the 0.383 coefficient on the c924 path.
- ADDR  out  4  index m of the sample currently presented.
- FRM_DONE  out  1  one-cycle pulse after the second phase of sample 15.
- START_ERR  out  1  one-cycle pulse when START is asserted outside IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0. Reset is asynchronous and takes effect mid-frame; no partial frame resumes afterwards.
- Every register update and every pulse is qualified by EI. With EI low, nothing changes and pulses hold their current value.
- FSM states: IDLE, PH0, PH1.
  - IDLE: IN_RDY=0. START → PH0 with cnt=0.
  - PH0: IN_RDY=1. On accept:
    - register DIR/DII into DOR/DOI;
    - ED<=1; ADDR<=cnt; register flags decoded from cnt;
    - → PH1.
    - Without IN_VLD: ED<=0, stay in PH0; gaps are unbounded.
  - PH1: IN_RDY=0; ED<=0; DOR/DOI/flags/ADDR held.
    - cnt==15: cnt<=0, FRM_DONE<=1, → IDLE.
    - otherwise: cnt++, → PH0.
- Latency: a sample accepted at edge t appears on DOR/DOI with ED=1 after t. It is held through the following EI cycle with ED=0. The maximum rate is one sample per 2 EI cycles.
- Exponent: n2=cnt[1:0], k1=cnt[3:2], e=n2*k1, giving e ∈ {0,1,2,3,4,6,9}.
- Decode table (SEL, MPYJ, C383):
  - e=0 → (0,0,0)
  - e=1 → (1,0,0)
  - e=2 → (2,0,0)
  - e=3 → (1,1,1)
  - e=4 → (0,1,0)
  - e=6 → (2,1,0)
  - e=9 → (1,1,0)
- START outside IDLE is ignored and pulses START_ERR. START held high in IDLE on the same edge that FRM_DONE fires is not seen; the next frame begins the following cycle.
- DOR/DOI pass through without arithmetic; no width growth.

Decomposition:
- Package fft16_pkg holds:
  - state enum;
  - SEL encodings (SEL_BYP, SEL_924, SEL_707);
  - 16-entry constant ROT_LUT[cnt] → {SEL, MPYJ, C383}, derived from the e table.
- One natural sub-module: fft16_rot_decode (cnt → flags, combinational LUT). The FSM, counter and data registers stay in the top.

Test Plan:
- Reset with RST_N=0 mid-frame at cnt=7, release → all outputs 0, IDLE; the next START restarts at ADDR=0.
- START, then IN_VLD continuous with DIR=m, DII=-m → ED pulses every 2 cycles; DOR=m on the ED cycle and on the following cycle.
  - Flag sequence over m=0..15 matches ROT_LUT: m=5 → (1,0,0), m=15 → (1,1,0), m=10 → (0,1,0).
  - FRM_DONE fires once after m=15.
- IN_VLD toggling with 0–3 cycle gaps → no ED without an accept; ADDR is strictly sequential; sample count is exactly 16.
- EI=0 for 5 cycles during PH1 → outputs and state frozen; resumes with ED=0 for one cycle, then PH0.
- START pulsed at cnt=4 → START_ERR=1 for one cycle; the frame completes normally with FRM_DONE after 16 samples.
- Back-to-back frames with START high continuously → the second frame begins one cycle after FRM_DONE; ADDR wraps 15→0.

Source files
------------

// File: rtl/fft16_pkg.sv
// Shared types and constants for the 16-point FFT twiddle sequencer.
//   state_t     : sequencer FSM states
//   SEL_*       : rotator path encodings
//   rot_flags_t : {sel, mpyj, c383} control bundle for the W16 rotator
//   ROT_LUT     : sample index m -> rotator flags, for e = m[1:0] * m[3:2]
package fft16_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPh0  = 2'd1,
    StPh1  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_BYP = 2'd0;
  localparam logic [1:0] SEL_924 = 2'd1;
  localparam logic [1:0] SEL_707 = 2'd2;

  typedef struct packed {
    logic [1:0] sel;
    logic       mpyj;
    logic       c383;
  } rot_flags_t;

  // Exponent to flags: 0->byp, 1->924, 2->707, 3->924*-j using 0.383,
  // 4->-j, 6->707*-j, 9->924*-j.
  localparam rot_flags_t ROT_LUT [16] = '{
    rot_flags_t'({SEL_BYP, 1'b0, 1'b0}),  // m=0  e=0
    rot_flags_t'({SEL_BYP, 1'b0, 1'b0}),  // m=1  e=0
    rot_flags_t'({SEL_BYP, 1'b0, 1'b0}),  // m=2  e=0
    rot_flags_t'({SEL_BYP, 1'b0, 1'b0}),  // m=3  e=0
    rot_flags_t'({SEL_BYP, 1'b0, 1'b0}),  // m=4  e=0
    rot_flags_t'({SEL_924, 1'b0, 1'b0}),  // m=5  e=1
    rot_flags_t'({SEL_707, 1'b0, 1'b0}),  // m=6  e=2
    rot_flags_t'({SEL_924, 1'b1, 1'b1}),  // m=7  e=3
    rot_flags_t'({SEL_BYP, 1'b0, 1'b0}),  // m=8  e=0
    rot_flags_t'({SEL_707, 1'b0, 1'b0}),  // m=9  e=2
    rot_flags_t'({SEL_BYP, 1'b1, 1'b0}),  // m=10 e=4
    rot_flags_t'({SEL_707, 1'b1, 1'b0}),  // m=11 e=6
    rot_flags_t'({SEL_BYP, 1'b0, 1'b0}),  // m=12 e=0
    rot_flags_t'({SEL_924, 1'b1, 1'b1}),  // m=13 e=3
    rot_flags_t'({SEL_707, 1'b1, 1'b0}),  // m=14 e=6
    rot_flags_t'({SEL_924, 1'b1, 1'b0})   // m=15 e=9
  };

endpackage

// File: rtl/fft16_twiddle_seq_if.sv
// Sample stream and rotator-side bus of the twiddle sequencer.
//   IN_VLD/IN_RDY/DIR/DII : input sample handshake
//   DOR/DOI/ED            : two-phase sample strobe to the rotator
//   SEL/MPYJ/C383/ADDR    : rotator control flags and sample index
// modport slave is the sequencer; master is the producer/consumer side.
interface fft16_twiddle_seq_if #(
  parameter int unsigned nb = 12
) ();

  logic          IN_VLD;
  logic          IN_RDY;
  logic [nb-1:0] DIR;
  logic [nb-1:0] DII;
  logic [nb-1:0] DOR;
  logic [nb-1:0] DOI;
  logic          ED;
  logic [1:0]    SEL;
  logic          MPYJ;
  logic          C383;
  logic [3:0]    ADDR;

  modport slave (
    input  IN_VLD, DIR, DII,
    output IN_RDY, DOR, DOI, ED, SEL, MPYJ, C383, ADDR
  );

  modport master (
    output IN_VLD, DIR, DII,
    input  IN_RDY, DOR, DOI, ED, SEL, MPYJ, C383, ADDR
  );

endinterface

// File: rtl/fft16_rot_decode.sv
// Combinational decode of the sample index into W16 rotator flags.
//   cnt_i   : sample index m within the 16-point frame
//   flags_o : {sel, mpyj, c383} for exponent m[1:0] * m[3:2]
module fft16_rot_decode
  import fft16_pkg::*;
(
  input  logic [3:0] cnt_i,
  output rot_flags_t flags_o
);

  always_comb begin
    flags_o = ROT_LUT[cnt_i];
  end

endmodule

// File: rtl/fft16_twiddle_seq.sv
// Twiddle sequencer feeding the W16 rotator between the radix-4 passes.
// Accepts one sample per handshake and presents it as a two-phase strobe
// (ED high, then ED low on the next EI cycle) with decoded rotator flags.
//   CLK, RST_N : clock, asynchronous active-low reset
//   EI         : global enable; all state and outputs hold while low
//   START      : begins a 16-sample frame (only honoured in idle)
//   FRM_DONE   : one-cycle pulse after the second phase of sample 15
//   START_ERR  : one-cycle pulse when START is seen outside idle
//   bus        : sample handshake in, rotator data/flags out
module fft16_twiddle_seq
  import fft16_pkg::*;
#(
  parameter int unsigned nb = 12
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EI,
  input  logic                START,
  output logic                FRM_DONE,
  output logic                START_ERR,
  fft16_twiddle_seq_if.slave  bus
);

  state_t     state_q;
  logic [3:0] cnt_q;
  rot_flags_t flags;

  fft16_rot_decode u_rot_decode (
    .cnt_i   (cnt_q),
    .flags_o (flags)
  );

  // IN_RDY is kept as a register that mirrors "state is PH0".
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      FRM_DONE   <= 1'b0;
      START_ERR  <= 1'b0;
      bus.IN_RDY <= 1'b0;
      bus.DOR    <= '0;
      bus.DOI    <= '0;
      bus.ED     <= 1'b0;
      bus.SEL    <= SEL_BYP;
      bus.MPYJ   <= 1'b0;
      bus.C383   <= 1'b0;
      bus.ADDR   <= 4'd0;
    end else if (EI) begin
      FRM_DONE  <= 1'b0;
      START_ERR <= START && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (START) begin
            state_q    <= StPh0;
            cnt_q      <= 4'd0;
            bus.IN_RDY <= 1'b1;
          end
        end
        StPh0: begin
          if (bus.IN_VLD) begin
            bus.DOR    <= bus.DIR;
            bus.DOI    <= bus.DII;
            bus.ED     <= 1'b1;
            bus.ADDR   <= cnt_q;
            bus.SEL    <= flags.sel;
            bus.MPYJ   <= flags.mpyj;
            bus.C383   <= flags.c383;
            bus.IN_RDY <= 1'b0;
            state_q    <= StPh1;
          end else begin
            bus.ED <= 1'b0;
          end
        end
        StPh1: begin
          bus.ED <= 1'b0;
          if (cnt_q == 4'd15) begin
            cnt_q    <= 4'd0;
            FRM_DONE <= 1'b1;
            state_q  <= StIdle;
          end else begin
            cnt_q      <= cnt_q + 4'd1;
            bus.IN_RDY <= 1'b1;
            state_q    <= StPh0;
          end
        end
        default: begin
          state_q    <= StIdle;
          bus.IN_RDY <= 1'b0;
          bus.ED     <= 1'b0;
        end
      endcase
    end
  end

endmodule
